// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares one 16-bit-address / 8-bit-data memory bus between the CPU core and
// a DMA requester. Each access runs IDLE -> ACCESS (WAIT_STATES+1 cycles) ->
// DONE, where the owner gets a one-cycle ready pulse. DMA has fixed priority,
// but after DMA_BURST_MAX consecutive DMA grants taken while the CPU was
// waiting, the CPU is granted the next slot.
//
// Ports
//   clk_in, reset            clock, asynchronous active-low reset
//   cpu_req/cpu_READ_write/cpu_address/cpu_data_out   CPU request inputs
//   cpu_data_in, cpu_ready   CPU read data and completion pulse
//   dma_req/dma_READ_write/dma_address/dma_wdata      DMA request inputs
//   dma_rdata, dma_ready     DMA read data and completion pulse
//   mem_enable/mem_READ_write/mem_address/mem_data_out memory request outputs
//   mem_data_in              memory read data
//   owner                    last granted requester (0 = CPU, 1 = DMA)
//   fsm_state                current state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Handshake: a requester raises *_req with its address, direction and write
// data and holds them stable until its *_ready pulse. The pulse lasts one
// cycle and marks completion; read data is valid from that cycle onward. A
// request still high during its own ready cycle is a new request, and a
// request dropped during ACCESS still completes with a ready pulse.
module bus_arbiter #(
    parameter int WAIT_STATES   = 1,
    parameter int DMA_BURST_MAX = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_READ_write,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic        dma_READ_write,
    input  logic [15:0] dma_address,
    input  logic [7:0]  dma_wdata,
    output logic [7:0]  dma_rdata,
    output logic        dma_ready,
    output logic        mem_enable,
    output logic        mem_READ_write,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_out,
    input  logic [7:0]  mem_data_in,
    output logic        owner,
    output logic [1:0]  fsm_state
);

    localparam logic [2:0] WS   = 3'(WAIT_STATES);
    localparam logic [3:0] BMAX = 4'(DMA_BURST_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] wait_cnt;
    logic [3:0] dma_streak;
    logic       grant_dma;

    // DMA wins a contested slot unless it has already taken BMAX in a row
    // while the CPU was waiting.
    always_comb begin
        grant_dma = dma_req && (!cpu_req || (dma_streak != BMAX));
    end

    assign fsm_state = state;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            wait_cnt       <= 3'd0;
            dma_streak     <= 4'd0;
            mem_enable     <= 1'b0;
            mem_READ_write <= 1'b1;
            mem_address    <= 16'h0000;
            mem_data_out   <= 8'h00;
            cpu_data_in    <= 8'h00;
            dma_rdata      <= 8'h00;
            cpu_ready      <= 1'b0;
            dma_ready      <= 1'b0;
            owner          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        owner      <= grant_dma;
                        mem_enable <= 1'b1;
                        wait_cnt   <= WS;
                        state      <= ACCESS;
                        if (grant_dma) begin
                            mem_address    <= dma_address;
                            mem_READ_write <= dma_READ_write;
                            mem_data_out   <= dma_READ_write ? 8'h00 : dma_wdata;
                        end else begin
                            mem_address    <= cpu_address;
                            mem_READ_write <= cpu_READ_write;
                            mem_data_out   <= cpu_READ_write ? 8'h00 : cpu_data_out;
                        end
                        // Streak counts only DMA grants that made the CPU wait.
                        if (grant_dma && cpu_req) begin
                            if (dma_streak != BMAX) begin
                                dma_streak <= dma_streak + 4'd1;
                            end
                        end else begin
                            dma_streak <= 4'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 3'd0) begin
                        mem_enable <= 1'b0;
                        state      <= DONE;
                        if (owner) begin
                            dma_ready <= 1'b1;
                            if (mem_READ_write) begin
                                dma_rdata <= mem_data_in;
                            end
                        end else begin
                            cpu_ready <= 1'b1;
                            if (mem_READ_write) begin
                                cpu_data_in <= mem_data_in;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                DONE: begin
                    cpu_ready <= 1'b0;
                    dma_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b0;
  logic        cpu_req = 1'b0, cpu_READ_write = 1'b1;
  logic [15:0] cpu_address = 16'h0;
  logic [7:0]  cpu_data_out = 8'h0;
  logic [7:0]  cpu_data_in;
  logic        cpu_ready;
  logic        dma_req = 1'b0, dma_READ_write = 1'b1;
  logic [15:0] dma_address = 16'h0;
  logic [7:0]  dma_wdata = 8'h0;
  logic [7:0]  dma_rdata;
  logic        dma_ready;
  logic        mem_enable, mem_READ_write;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in = 8'h0;
  logic        owner;
  logic [1:0]  fsm_state;

  // second instance, WAIT_STATES = 0
  logic        w_cpu_req = 1'b0;
  logic [15:0] w_cpu_address = 16'h0;
  logic [7:0]  w_cpu_data_in, w_dma_rdata, w_mem_data_out;
  logic        w_cpu_ready, w_dma_ready, w_mem_enable, w_mem_rw, w_owner;
  logic [15:0] w_mem_address;
  logic [1:0]  w_fsm_state;

  int n_vec = 0;
  int n_bad = 0;
  logic [0:0] exp_q[$];

  bus_arbiter #(.WAIT_STATES(1), .DMA_BURST_MAX(4)) u_dut (
    .clk_in(clk_in), .reset(reset),
    .cpu_req(cpu_req), .cpu_READ_write(cpu_READ_write), .cpu_address(cpu_address),
    .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_READ_write(dma_READ_write), .dma_address(dma_address),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_enable(mem_enable), .mem_READ_write(mem_READ_write), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .owner(owner),
    .fsm_state(fsm_state)
  );

  bus_arbiter #(.WAIT_STATES(0), .DMA_BURST_MAX(4)) u_ws0 (
    .clk_in(clk_in), .reset(reset),
    .cpu_req(w_cpu_req), .cpu_READ_write(1'b1), .cpu_address(w_cpu_address),
    .cpu_data_out(8'h00), .cpu_data_in(w_cpu_data_in), .cpu_ready(w_cpu_ready),
    .dma_req(1'b0), .dma_READ_write(1'b1), .dma_address(16'h0000),
    .dma_wdata(8'h00), .dma_rdata(w_dma_rdata), .dma_ready(w_dma_ready),
    .mem_enable(w_mem_enable), .mem_READ_write(w_mem_rw), .mem_address(w_mem_address),
    .mem_data_out(w_mem_data_out), .mem_data_in(mem_data_in), .owner(w_owner),
    .fsm_state(w_fsm_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    if (mem_enable !== 1'b0) begin $display("FAIL rst_en: got %b want 0", mem_enable); n_bad++; end
    n_vec++;
    if (mem_READ_write !== 1'b1) begin $display("FAIL rst_rw: got %b want 1", mem_READ_write); n_bad++; end
    n_vec++;
    if (mem_address !== 16'h0000) begin $display("FAIL rst_addr: got %h want 0000", mem_address); n_bad++; end
    n_vec++;
    if (mem_data_out !== 8'h00) begin $display("FAIL rst_wd: got %h want 00", mem_data_out); n_bad++; end
    n_vec++;
    if ({cpu_ready, dma_ready, owner} !== 3'b000) begin $display("FAIL rst_rdy_own: got %b want 000", {cpu_ready, dma_ready, owner}); n_bad++; end
    n_vec++;
    if ({cpu_data_in, dma_rdata} !== 16'h0000) begin $display("FAIL rst_rdata: got %h want 0000", {cpu_data_in, dma_rdata}); n_bad++; end
    n_vec++;
    if (fsm_state !== 2'd0) begin $display("FAIL rst_state: got %0d want 0", fsm_state); n_bad++; end
    n_vec++;
    reset = 1'b1;
    tick();
    if (mem_enable !== 1'b0) begin $display("FAIL idle_no_req: got %b want 0", mem_enable); n_bad++; end
    n_vec++;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_READ_write = 1'b1; cpu_address = 16'h1234; mem_data_in = 8'hA9;
    for (int k = 0; k < 2; k++) begin
      tick();
      if ({mem_enable, mem_READ_write, mem_address} !== {2'b11, 16'h1234}) begin
        $display("FAIL cpu_rd_access%0d: got en=%b rw=%b a=%h want en=1 rw=1 a=1234", k, mem_enable, mem_READ_write, mem_address); n_bad++;
      end
      n_vec++;
      if ({cpu_ready, owner, mem_data_out} !== 10'h000) begin
        $display("FAIL cpu_rd_own%0d: got rdy=%b own=%b wd=%h want 0 0 00", k, cpu_ready, owner, mem_data_out); n_bad++;
      end
      n_vec++;
    end
    tick();
    if ({mem_enable, cpu_ready, cpu_data_in} !== {2'b01, 8'hA9}) begin
      $display("FAIL cpu_rd_done: got en=%b rdy=%b d=%h want en=0 rdy=1 d=a9", mem_enable, cpu_ready, cpu_data_in); n_bad++;
    end
    n_vec++;
    cpu_req = 1'b0;
    tick();
    if (cpu_ready !== 1'b0) begin $display("FAIL cpu_rd_pulse: got %b want 0", cpu_ready); n_bad++; end
    n_vec++;
    tick();
    if (mem_enable !== 1'b0) begin $display("FAIL cpu_rd_noregrant: got %b want 0", mem_enable); n_bad++; end
    n_vec++;
  endtask

  task automatic test_dma_write();
    dma_req = 1'b1; dma_READ_write = 1'b0; dma_address = 16'h0200; dma_wdata = 8'h55; mem_data_in = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      tick();
      if ({mem_enable, mem_READ_write, mem_address, mem_data_out, owner} !== {2'b10, 16'h0200, 8'h55, 1'b1}) begin
        $display("FAIL dma_wr_access%0d: got en=%b rw=%b a=%h wd=%h own=%b want 1 0 0200 55 1",
                 k, mem_enable, mem_READ_write, mem_address, mem_data_out, owner); n_bad++;
      end
      n_vec++;
    end
    tick();
    if ({mem_enable, dma_ready, cpu_ready, dma_rdata} !== {3'b010, 8'h00}) begin
      $display("FAIL dma_wr_done: got en=%b drdy=%b crdy=%b rd=%h want 0 1 0 00", mem_enable, dma_ready, cpu_ready, dma_rdata); n_bad++;
    end
    n_vec++;
    dma_req = 1'b0;
    tick();
    if (dma_ready !== 1'b0) begin $display("FAIL dma_wr_pulse: got %b want 0", dma_ready); n_bad++; end
    n_vec++;
    tick();
  endtask

  task automatic test_arbitration();
    int done_cyc[$];
    int got;
    logic [0:0] e;
    exp_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cpu_req = 1'b1; cpu_READ_write = 1'b1; cpu_address = 16'h1000;
    dma_req = 1'b1; dma_READ_write = 1'b1; dma_address = 16'h2000;
    mem_data_in = 8'h11;
    got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      tick();
      if (cpu_ready || dma_ready) begin
        e = exp_q.pop_front();
        if ({dma_ready, cpu_ready} !== {e, ~e}) begin
          $display("FAIL arb_order%0d: got dma_rdy=%b cpu_rdy=%b want dma_rdy=%b", got, dma_ready, cpu_ready, e); n_bad++;
        end
        n_vec++;
        done_cyc.push_back(c);
        got++;
        if (got == 10) begin cpu_req = 1'b0; dma_req = 1'b0; end
      end
    end
    if (got != 10) begin $display("FAIL arb_count: got %0d completions want 10", got); n_bad++; end
    n_vec++;
    for (int i = 1; i < done_cyc.size(); i++) begin
      if (done_cyc[i] - done_cyc[i-1] != 4) begin
        $display("FAIL arb_spacing%0d: got %0d cycles want 4", i, done_cyc[i] - done_cyc[i-1]); n_bad++;
      end
      n_vec++;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    tick();
    if (mem_enable !== 1'b0) begin $display("FAIL arb_quiet: got %b want 0", mem_enable); n_bad++; end
    n_vec++;
  endtask

  task automatic test_dma_drop();
    dma_req = 1'b1; dma_READ_write = 1'b1; dma_address = 16'h0300; mem_data_in = 8'h9A;
    tick();
    if ({mem_enable, owner, mem_address} !== {2'b11, 16'h0300}) begin
      $display("FAIL drop_grant: got en=%b own=%b a=%h want 1 1 0300", mem_enable, owner, mem_address); n_bad++;
    end
    n_vec++;
    dma_req = 1'b0;
    tick();
    if (mem_enable !== 1'b1) begin $display("FAIL drop_hold: got %b want 1", mem_enable); n_bad++; end
    n_vec++;
    tick();
    if ({dma_ready, dma_rdata} !== {1'b1, 8'h9A}) begin
      $display("FAIL drop_done: got rdy=%b rd=%h want 1 9a", dma_ready, dma_rdata); n_bad++;
    end
    n_vec++;
    tick();
    tick();
    tick();
    if ({mem_enable, dma_ready, fsm_state} !== 4'b0000) begin
      $display("FAIL drop_idle: got en=%b rdy=%b st=%0d want 0 0 0", mem_enable, dma_ready, fsm_state); n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_READ_write = 1'b1; cpu_address = 16'h4321; mem_data_in = 8'h3C;
    tick();
    if (mem_enable !== 1'b1) begin $display("FAIL rmid_start: got %b want 1", mem_enable); n_bad++; end
    n_vec++;
    #2 reset = 1'b0;
    #1;
    if ({mem_enable, mem_READ_write, mem_address, mem_data_out, owner} !== {2'b01, 16'h0000, 8'h00, 1'b0}) begin
      $display("FAIL rmid_async: got en=%b rw=%b a=%h wd=%h own=%b want 0 1 0000 00 0",
               mem_enable, mem_READ_write, mem_address, mem_data_out, owner); n_bad++;
    end
    n_vec++;
    if ({cpu_data_in, dma_rdata, fsm_state} !== 18'h0) begin
      $display("FAIL rmid_regs: got cd=%h dd=%h st=%0d want 00 00 0", cpu_data_in, dma_rdata, fsm_state); n_bad++;
    end
    n_vec++;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (cpu_ready !== 1'b0) begin $display("FAIL rmid_noready%0d: got %b want 0", k, cpu_ready); n_bad++; end
      n_vec++;
    end
    reset = 1'b1;
    tick();
    if ({mem_enable, mem_address} !== {1'b1, 16'h4321}) begin
      $display("FAIL rmid_regrant: got en=%b a=%h want 1 4321", mem_enable, mem_address); n_bad++;
    end
    n_vec++;
    tick();
    tick();
    if ({cpu_ready, cpu_data_in} !== {1'b1, 8'h3C}) begin
      $display("FAIL rmid_done: got rdy=%b d=%h want 1 3c", cpu_ready, cpu_data_in); n_bad++;
    end
    n_vec++;
    cpu_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_ws0();
    w_cpu_req = 1'b1; w_cpu_address = 16'h00F0; mem_data_in = 8'h77;
    for (int k = 0; k < 9; k++) begin
      tick();
      if ({w_mem_enable, w_cpu_ready} !== {(k % 3) == 0, (k % 3) == 1}) begin
        $display("FAIL ws0_cycle%0d: got en=%b rdy=%b want en=%b rdy=%b",
                 k, w_mem_enable, w_cpu_ready, (k % 3) == 0, (k % 3) == 1); n_bad++;
      end
      n_vec++;
      if ((k % 3) == 1) begin
        if (w_cpu_data_in !== 8'h77) begin $display("FAIL ws0_data%0d: got %h want 77", k, w_cpu_data_in); n_bad++; end
        n_vec++;
      end
      if (k == 7) w_cpu_req = 1'b0;
    end
    tick();
    if (w_mem_enable !== 1'b0) begin $display("FAIL ws0_stop: got %b want 0", w_mem_enable); n_bad++; end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_arbitration();
    test_dma_drop();
    test_reset_mid();
    test_ws0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
